// File: rtl/fpalu_arbiter_if.sv
// fpalu_arbiter_if: bundle between two FPALU requesters, the arbiter and the FPALU.
//   req0_* / req1_* : valid/ready issue ports (opcode, operands A/B) for ch0/ch1
//   alu_*           : registered FPALU inputs, alu_y is the FPALU result
//   rsp0/1_valid    : one-cycle result pulses, rsp_y shared result data
//   busy            : operations in flight or a mode-switch drain in progress
// Modports: slave = arbiter side, master = requester/FPALU side.
interface fpalu_arbiter_if #(parameter int W = 29);
  logic         req0_valid, req0_ready;
  logic [1:0]   req0_op;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [1:0]   req1_op;
  logic [W-1:0] req1_a, req1_b;
  logic [1:0]   alu_opcode;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_y;
  logic         busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_opcode, alu_a, alu_b,
    input  alu_y,
    output rsp0_valid, rsp1_valid, rsp_y, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_opcode, alu_a, alu_b,
    output alu_y,
    input  rsp0_valid, rsp1_valid, rsp_y, busy
  );
endinterface

// File: rtl/fpalu_arbiter.sv
// fpalu_arbiter: shares one fixed-latency FPALU between two requesters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fpalu_arbiter_if.slave (request ports, FPALU ports, responses, busy)
//   Optional macro FPALU_ARB_PERF_EN adds perf_issue0/perf_issue1/perf_drain
//   16-bit saturating counters (accepted issues per channel, DRAIN cycles).
// Round-robin issue, one operand register stage, LAT-deep tag pipe routing each
// result back to its issuer. The FPALU opcode may only change while no
// operation is inside the FPALU; a mismatching winner waits in DRAIN.
module fpalu_arbiter #(
  parameter int LAT = 2,   // FPALU latency, operand register -> valid alu_y (1..8)
  parameter int W   = 29
) (
  input  logic            clk,
  input  logic            rst,
  fpalu_arbiter_if.slave  bus
`ifdef FPALU_ARB_PERF_EN
  ,
  output logic [15:0]     perf_issue0,
  output logic [15:0]     perf_issue1,
  output logic [15:0]     perf_drain
`endif
);
  typedef enum logic {RUN, DRAIN} state_t;
  localparam logic [1:0] OP_RST = 2'b10;

  state_t       state, state_nxt;
  logic         rr;                  // preferred channel when both request
  logic         drain_ch, drain_ch_nxt;
  // vld_pipe[i]/ch_pipe[i]: tag of the op i cycles past the operand register;
  // index LAT is the tag aligned with the current alu_y.
  logic [LAT:0] vld_pipe, ch_pipe;
  logic         win_vld, win_ch, pipe_empty, issue, issue_ch;
  logic [1:0]   win_op;

  assign win_vld    = bus.req0_valid | bus.req1_valid;
  assign win_ch     = (bus.req0_valid & bus.req1_valid) ? rr : bus.req1_valid;
  assign win_op     = win_ch ? bus.req1_op : bus.req0_op;
  // Stage LAT is already out of the FPALU, so it does not block a mode switch.
  assign pipe_empty = ~|vld_pipe[LAT-1:0];

  always_comb begin
    state_nxt    = state;
    drain_ch_nxt = drain_ch;
    issue        = 1'b0;
    issue_ch     = win_ch;
    if (!rst) begin
      case (state)
        RUN: begin
          if (win_vld) begin
            if (win_op == bus.alu_opcode || pipe_empty) begin
              issue = 1'b1;
            end else begin
              state_nxt    = DRAIN;
              drain_ch_nxt = win_ch;
            end
          end
        end
        DRAIN: begin
          // Latched winner keeps priority; the other channel cannot overtake it.
          issue_ch = drain_ch;
          if (pipe_empty) begin
            state_nxt = RUN;
            issue     = drain_ch ? bus.req1_valid : bus.req0_valid;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign bus.req0_ready = issue & ~issue_ch;
  assign bus.req1_ready = issue & issue_ch;
  assign bus.busy       = (|vld_pipe) | (state == DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      drain_ch <= 1'b0;
      rr       <= 1'b0;
    end else begin
      state    <= state_nxt;
      drain_ch <= drain_ch_nxt;
      if (issue) rr <= ~issue_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_opcode <= OP_RST;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      vld_pipe       <= '0;
      ch_pipe        <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp_y      <= '0;
    end else begin
      if (issue) begin
        bus.alu_opcode <= issue_ch ? bus.req1_op : bus.req0_op;
        bus.alu_a      <= issue_ch ? bus.req1_a  : bus.req0_a;
        bus.alu_b      <= issue_ch ? bus.req1_b  : bus.req0_b;
      end
      vld_pipe       <= {vld_pipe[LAT-1:0], issue};
      ch_pipe        <= {ch_pipe[LAT-1:0], issue_ch};
      bus.rsp0_valid <= vld_pipe[LAT] & ~ch_pipe[LAT];
      bus.rsp1_valid <= vld_pipe[LAT] & ch_pipe[LAT];
      if (vld_pipe[LAT]) bus.rsp_y <= bus.alu_y;
    end
  end

`ifdef FPALU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue0 <= '0;
      perf_issue1 <= '0;
      perf_drain  <= '0;
    end else begin
      if (issue && !issue_ch && perf_issue0 != 16'hFFFF) perf_issue0 <= perf_issue0 + 16'd1;
      if (issue && issue_ch && perf_issue1 != 16'hFFFF)  perf_issue1 <= perf_issue1 + 16'd1;
      if (state == DRAIN && perf_drain != 16'hFFFF)      perf_drain  <= perf_drain + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fpalu_arbiter.sv
// tb_fpalu_arbiter: random + directed stimulus, transaction-level reference model,
// scoreboard queue of expected results popped by an independent response monitor.
// Defining FPALU_ARB_PERF_EN also checks the performance counters.
module tb_fpalu_arbiter;
  localparam int LAT = 2;
  localparam int W   = 29;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpalu_arbiter_if #(.W(W)) bus();

`ifdef FPALU_ARB_PERF_EN
  logic [15:0] perf_issue0, perf_issue1, perf_drain;
`endif

  fpalu_arbiter #(.LAT(LAT), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FPALU_ARB_PERF_EN
    ,
    .perf_issue0 (perf_issue0),
    .perf_issue1 (perf_issue1),
    .perf_drain  (perf_drain)
`endif
  );

  // FPALU stub: y = a ^ b, LAT cycles after the operand register.
  logic [LAT-1:0][W-1:0] stub;
  always @(posedge clk) begin
    stub[0] <= bus.alu_a ^ bus.alu_b;
    for (int i = 1; i < LAT; i++) stub[i] <= stub[i-1];
  end
  assign bus.alu_y = stub[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit           ch;
    logic [W-1:0] y;
    int           due;
  } exp_t;
  exp_t sbq[$];

  int         pref = 0;       // channel preferred on a tie
  int         pend = -1;      // channel waiting for the FPALU to empty, -1 none
  int         last_iss = 0;   // cycle of most recent accepted issue
  bit         have_iss = 0;
  logic [1:0] cur_op = 2'b10;

  bit           mv [2];
  logic [1:0]   mop[2];
  logic [W-1:0] ma [2], mb[2];
  int           g, w;
  bit           fpalu_busy, exp_busy;
  exp_t         e;

  always @(negedge clk) begin
    mv[0] = bus.req0_valid; mop[0] = bus.req0_op; ma[0] = bus.req0_a; mb[0] = bus.req0_b;
    mv[1] = bus.req1_valid; mop[1] = bus.req1_op; ma[1] = bus.req1_a; mb[1] = bus.req1_b;
    if (rst) begin
      chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
      pref = 0; pend = -1; have_iss = 0; cur_op = 2'b10;
      sbq.delete();
    end else begin
      // An op issued at cycle c is inside the FPALU during c+1..c+LAT and its
      // tag is visible one more cycle while the result is captured.
      fpalu_busy = have_iss && (cyc - last_iss <= LAT);
      exp_busy   = (pend >= 0) || (have_iss && (cyc - last_iss <= LAT + 1));
      g = -1;
      if (pend >= 0) begin
        if (!fpalu_busy) begin
          if (mv[pend]) g = pend;
          pend = -1;
        end
      end else if (mv[0] || mv[1]) begin
        w = (mv[0] && mv[1]) ? pref : (mv[1] ? 1 : 0);
        if (mop[w] == cur_op || !fpalu_busy) g = w;
        else pend = w;
      end
      chk("ready0", {31'd0, bus.req0_ready}, {31'd0, g == 0});
      chk("ready1", {31'd0, bus.req1_ready}, {31'd0, g == 1});
      chk("alu_opcode", {30'd0, bus.alu_opcode}, {30'd0, cur_op});
      chk("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
      if (g >= 0) begin
        pref     = 1 - g;
        cur_op   = mop[g];
        last_iss = cyc;
        have_iss = 1;
        e.ch  = (g == 1);
        e.y   = ma[g] ^ mb[g];
        e.due = cyc + 2 + LAT;
        sbq.push_back(e);
      end
    end
  end

  // ---------------- response monitor ----------------
  int   rsp_cnt0 = 0, rsp_cnt1 = 0;
  exp_t got;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp0_valid) rsp_cnt0++;
      if (bus.rsp1_valid) rsp_cnt1++;
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        chk("rsp_one_hot", {31'd0, bus.rsp0_valid & bus.rsp1_valid}, 32'd0);
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          got = sbq.pop_front();
          chk("rsp_ch", {31'd0, bus.rsp1_valid}, {31'd0, got.ch});
          chk("rsp_y", {3'd0, bus.rsp_y}, {3'd0, got.y});
          chk("rsp_cycle", cyc, got.due);
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        chk("rsp_missing", 32'd0, 32'd1);
        void'(sbq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  bit acc0 = 0, acc1 = 0;
  always @(negedge clk) begin
    acc0 = bus.req0_ready;
    acc1 = bus.req1_ready;
  end

  // New operand data only once the previous request was taken or dropped.
  task automatic set_req(input bit v0, input logic [1:0] o0, input bit v1, input logic [1:0] o1);
    if (acc0 || !bus.req0_valid) begin bus.req0_a = W'($urandom); bus.req0_b = W'($urandom); end
    if (acc1 || !bus.req1_valid) begin bus.req1_a = W'($urandom); bus.req1_b = W'($urandom); end
    bus.req0_valid = v0; bus.req0_op = o0;
    bus.req1_valid = v1; bus.req1_op = o1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_req(0, 2'b10, 0, 2'b10);
    repeat (n) tick();
  endtask

  function automatic logic [1:0] rnd_op();
    int r;
    r = $urandom_range(0, 19);
    if (r < 9) return 2'b10;
    if (r < 18) return 2'b11;
    return (r == 18) ? 2'b00 : 2'b01;
  endfunction

  int t, c0, c1, rtot, rcyc;
  logic [W-1:0] ry;
  bit prev_r0, v0, v1;
  logic [1:0] o0, o1;

  initial begin
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_op = 2'b10; bus.req1_op = 2'b10;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    rst = 1;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk("reset_alu_a", {3'd0, bus.alu_a}, 32'd0);
    chk("reset_alu_b", {3'd0, bus.alu_b}, 32'd0);
    chk("reset_rsp_y", {3'd0, bus.rsp_y}, 32'd0);
    chk("reset_rsp", {30'd0, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
    chk("reset_opcode", {30'd0, bus.alu_opcode}, 32'd2);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    tick();

    // Mode switch with DRAIN, plus a competing same-mode request during DRAIN.
    set_req(1, 2'b10, 0, 2'b10);
    @(negedge clk); t = cyc;
    chk("s3_ready0_t", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    set_req(0, 2'b10, 1, 2'b11);
    @(negedge clk);
    chk("s3_ready1_t1", {31'd0, bus.req1_ready}, 32'd0);
    chk("s3_busy_t1", {31'd0, bus.busy}, 32'd1);
    tick();
    set_req(1, 2'b11, 1, 2'b11);
    @(negedge clk);
    chk("s4_ready_t2", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
    chk("s3_busy_t2", {31'd0, bus.busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("s3_accept_cycle", cyc, t + 3);
    chk("s3_ready1_t3", {31'd0, bus.req1_ready}, 32'd1);
    chk("s4_ready0_t3", {31'd0, bus.req0_ready}, 32'd0);
    chk("s3_busy_t3", {31'd0, bus.busy}, 32'd1);
    tick();
    set_req(1, 2'b11, 0, 2'b11);
    @(negedge clk);
    chk("s3_opcode_t4", {30'd0, bus.alu_opcode}, 32'd3);
    chk("s4_ready0_t4", {31'd0, bus.req0_ready}, 32'd1);
`ifdef FPALU_ARB_PERF_EN
    chk("perf_issue0", {16'd0, perf_issue0}, 32'd1);
    chk("perf_issue1", {16'd0, perf_issue1}, 32'd1);
    chk("perf_drain", {16'd0, perf_drain}, 32'd2);
`endif
    tick();
    idle(8);

    // Single ch0 op with known operands.
    set_req(1, 2'b10, 0, 2'b10);
    bus.req0_a = 29'h0400_0001; bus.req0_b = 29'h0000_0003;
    @(negedge clk); t = cyc;
    chk("s1_ready0", {31'd0, bus.req0_ready}, 32'd1);
    c1 = rsp_cnt1; rcyc = -1; ry = '0;
    tick();
    set_req(0, 2'b10, 0, 2'b10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid && rcyc < 0) begin rcyc = cyc; ry = bus.rsp_y; end
      tick();
    end
    chk("s1_rsp_cycle", rcyc, t + 4);
    chk("s1_rsp_y", {3'd0, ry}, 32'h0400_0002);
    chk("s1_no_rsp1", rsp_cnt1, c1);

    // Both channels streaming the same opcode: strict alternation.
    c0 = rsp_cnt0; c1 = rsp_cnt1; prev_r0 = 0;
    for (int i = 0; i < 100; i++) begin
      set_req(1, 2'b10, 1, 2'b10);
      @(negedge clk);
      chk("s2_one_ready", {31'd0, bus.req0_ready ^ bus.req1_ready}, 32'd1);
      if (i > 0) chk("s2_alternate", {31'd0, bus.req0_ready}, {31'd0, ~prev_r0});
      prev_r0 = bus.req0_ready;
      tick();
    end
    idle(8);
    chk("s2_rsp0_count", rsp_cnt0 - c0, 50);
    chk("s2_rsp1_count", rsp_cnt1 - c1, 50);

    // Reset with two ops in flight.
    set_req(1, 2'b10, 0, 2'b10);
    tick(); tick();
    set_req(0, 2'b10, 0, 2'b10);
    rst = 1;
    tick();
    rst = 0;
    rtot = rsp_cnt0 + rsp_cnt1;
    set_req(1, 2'b11, 0, 2'b10);
    @(negedge clk);
    chk("s5_opcode", {30'd0, bus.alu_opcode}, 32'd2);
    chk("s5_alu_a", {3'd0, bus.alu_a}, 32'd0);
    chk("s5_rsp_y", {3'd0, bus.rsp_y}, 32'd0);
    chk("s5_ready0", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    set_req(0, 2'b10, 0, 2'b10);
    repeat (3) tick();
    chk("s5_no_stale_rsp", rsp_cnt0 + rsp_cnt1 - rtot, 0);
    idle(6);

    // Random traffic with mode switches, dropped requests and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (bus.req0_valid && !acc0 && $urandom_range(0, 9) < 8) begin v0 = 1; o0 = bus.req0_op; end
      else begin v0 = ($urandom_range(0, 9) < 6); o0 = rnd_op(); end
      if (bus.req1_valid && !acc1 && $urandom_range(0, 9) < 8) begin v1 = 1; o1 = bus.req1_op; end
      else begin v1 = ($urandom_range(0, 9) < 6); o1 = rnd_op(); end
      rst = ($urandom_range(0, 199) == 0);
      set_req(v0, o0, v1, o1);
      tick();
    end
    rst = 0;
    idle(12);
    chk("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
